// File: rtl/tag_release_queue_if.sv
// Commit-side and freelist-side signal bundle for tag_release_queue.
// The master modport is the ROB/freelist side; the slave modport is the queue.
`ifndef PHY_REG_SEL
`define PHY_REG_SEL 6
`endif

interface tag_release_queue_if #(
  parameter int TAG_W = `PHY_REG_SEL,
  parameter int PTR_W = 3
);
  logic             com_valid1;
  logic             com_valid2;
  logic             com_wr1;
  logic             com_wr2;
  logic [TAG_W-1:0] old_tag1;
  logic [TAG_W-1:0] old_tag2;
  logic             com_ready;
  logic             drain_en;
  logic [TAG_W-1:0] released_tag1;
  logic [TAG_W-1:0] released_tag2;
  logic [1:0]       comnum;
  logic [PTR_W:0]   count;

  modport master (
    output com_valid1, com_valid2, com_wr1, com_wr2, old_tag1, old_tag2, drain_en,
    input  com_ready, released_tag1, released_tag2, comnum, count
  );

  modport slave (
    input  com_valid1, com_valid2, com_wr1, com_wr2, old_tag1, old_tag2, drain_en,
    output com_ready, released_tag1, released_tag2, comnum, count
  );
endinterface

// File: rtl/tag_release_queue.sv
// In-order return queue of retired physical tags from commit to the freelist.
// Optional RELQ_BYPASS_EN: an empty draining queue forwards new tags in one cycle.
module tag_release_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int TAG_W = `PHY_REG_SEL
) (
  input  logic              clk,
  input  logic              reset,
  tag_release_queue_if.slave relq
);

  typedef logic [TAG_W-1:0] tag_t;

  localparam logic [PTR_W:0]   DEPTH_N = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   TWO_N   = (PTR_W+1)'(2);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  tag_t             mem_q [DEPTH];
  tag_t             mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  tag_t             rel1_q, rel1_d;
  tag_t             rel2_q, rel2_d;
  logic [1:0]       comnum_q, comnum_d;

  logic             req1, req2;
  logic             ready;
  logic [1:0]       enq_n;
  logic [1:0]       pop_n;
  tag_t             first_tag, second_tag;
  logic             bypass;
  logic [PTR_W-1:0] head_p1, tail_p1;

  // Readiness uses only the registered count so the ROB sees a stable signal.
  assign ready   = (DEPTH_N - count_q) >= TWO_N;
  assign head_p1 = head_q + ONE_P;
  assign tail_p1 = tail_q + ONE_P;

  always_comb begin
    req1       = relq.com_valid1 & relq.com_wr1;
    req2       = relq.com_valid2 & relq.com_wr2;
    enq_n      = 2'd0;
    first_tag  = '0;
    second_tag = '0;
    if (ready) begin
      case ({req1, req2})
        2'b11: begin
          enq_n      = 2'd2;
          first_tag  = relq.old_tag1;
          second_tag = relq.old_tag2;
        end
        2'b10: begin
          enq_n     = 2'd1;
          first_tag = relq.old_tag1;
        end
        2'b01: begin
          enq_n     = 2'd1;
          first_tag = relq.old_tag2;
        end
        default: begin
          enq_n = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    pop_n = 2'd0;
    if (relq.drain_en) begin
      if (count_q >= TWO_N) begin
        pop_n = 2'd2;
      end else begin
        pop_n = count_q[1:0];
      end
    end
`ifdef RELQ_BYPASS_EN
    bypass = relq.drain_en && (count_q == '0);
`else
    bypass = 1'b0;
`endif
  end

  always_comb begin
    mem_d    = mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    rel1_d   = rel1_q;
    rel2_d   = rel2_q;
    comnum_d = 2'd0;
    if (bypass) begin
      comnum_d = enq_n;
      rel1_d   = first_tag;
      rel2_d   = second_tag;
    end else begin
      if (enq_n != 2'd0) begin
        mem_d[tail_q] = first_tag;
      end
      if (enq_n == 2'd2) begin
        mem_d[tail_p1] = second_tag;
      end
      tail_d = tail_q + PTR_W'(enq_n);
      // Popped entries come from the pre-enqueue contents, so new tags wait a cycle.
      if (relq.drain_en) begin
        comnum_d = pop_n;
        rel1_d   = (pop_n != 2'd0) ? mem_q[head_q] : '0;
        rel2_d   = (pop_n == 2'd2) ? mem_q[head_p1] : '0;
      end
      head_d  = head_q + PTR_W'(pop_n);
      count_d = count_q + (PTR_W+1)'(enq_n) - (PTR_W+1)'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rel1_q   <= '0;
      rel2_q   <= '0;
      comnum_q <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rel1_q   <= rel1_d;
      rel2_q   <= rel2_d;
      comnum_q <= comnum_d;
    end
  end

  assign relq.com_ready     = ready;
  assign relq.released_tag1 = rel1_q;
  assign relq.released_tag2 = rel2_q;
  assign relq.comnum        = comnum_q;
  assign relq.count         = count_q;

endmodule

// File: tb/tb_tag_release_queue.sv
// Directed bench for tag_release_queue: a queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios (RELQ_BYPASS_EN aware).
module tb_tag_release_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int TAG_W = 6;
`ifdef RELQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  tag_release_queue_if #(.TAG_W(TAG_W), .PTR_W(PTR_W)) relq ();

  tag_release_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .relq  (relq)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents as a plain list of tags.
  int q[$];
  int nt[$];
  int m_comnum = 0;
  int m_t1 = 0;
  int m_t2 = 0;
  bit m_known = 1'b1;

  always @(posedge clk) begin
    int sz;
    int n;
    if (reset) begin
      q.delete();
      m_comnum = 0;
      m_t1 = 0;
      m_t2 = 0;
      m_known = 1'b1;
    end else begin
      sz = q.size();
      nt.delete();
      if ((DEPTH - sz) >= 2) begin
        if (relq.com_valid1 && relq.com_wr1) nt.push_back(int'(relq.old_tag1));
        if (relq.com_valid2 && relq.com_wr2) nt.push_back(int'(relq.old_tag2));
      end
      if (BYPASS && relq.drain_en && sz == 0) begin
        m_comnum = nt.size();
        m_t1 = (nt.size() > 0) ? nt[0] : 0;
        m_t2 = (nt.size() > 1) ? nt[1] : 0;
        m_known = 1'b1;
      end else begin
        if (relq.drain_en) begin
          n = (sz < 2) ? sz : 2;
          m_comnum = n;
          m_known = (n > 0);
          if (n > 0) m_t1 = q.pop_front();
          m_t2 = (n > 1) ? q.pop_front() : 0;
        end else begin
          m_comnum = 0;
        end
        foreach (nt[i]) q.push_back(nt[i]);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_count", int'(relq.count), q.size());
      checkOutput("model_com_ready", int'(relq.com_ready), ((DEPTH - q.size()) >= 2) ? 1 : 0);
      checkOutput("model_comnum", int'(relq.comnum), m_comnum);
      if (m_known) begin
        checkOutput("model_tag1", int'(relq.released_tag1), m_t1);
        checkOutput("model_tag2", int'(relq.released_tag2), m_t2);
      end
    end
  end

  task automatic applyStimulus(input bit v1, input bit w1, input int t1,
                               input bit v2, input bit w2, input int t2,
                               input bit drain);
    relq.com_valid1 = v1;
    relq.com_wr1    = w1;
    relq.old_tag1   = TAG_W'(t1);
    relq.com_valid2 = v2;
    relq.com_wr2    = w2;
    relq.old_tag2   = TAG_W'(t2);
    relq.drain_en   = drain;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    relq.com_valid1 = 1'b0;
    relq.com_valid2 = 1'b0;
    relq.com_wr1    = 1'b0;
    relq.com_wr2    = 1'b0;
    relq.old_tag1   = '0;
    relq.old_tag2   = '0;
    relq.drain_en   = 1'b0;

    // Reset held for two cycles.
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    checkOutput("reset_count", int'(relq.count), 0);
    checkOutput("reset_comnum", int'(relq.comnum), 0);
    checkOutput("reset_com_ready", int'(relq.com_ready), 1);
    checkOutput("reset_tag1", int'(relq.released_tag1), 0);
    checkOutput("reset_tag2", int'(relq.released_tag2), 0);

    // Slot 2 only, tag 5, while draining.
    applyStimulus(0, 0, 0, 1, 1, 5, 1);
`ifdef RELQ_BYPASS_EN
    checkOutput("slot2_bypass_comnum", int'(relq.comnum), 1);
    checkOutput("slot2_bypass_tag1", int'(relq.released_tag1), 5);
    checkOutput("slot2_bypass_tag2", int'(relq.released_tag2), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
`else
    checkOutput("slot2_queued_count", int'(relq.count), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("slot2_comnum", int'(relq.comnum), 1);
    checkOutput("slot2_tag1", int'(relq.released_tag1), 5);
    checkOutput("slot2_tag2", int'(relq.released_tag2), 0);
`endif
    checkOutput("slot2_count", int'(relq.count), 0);

    // Fill to full with tags 1..8, then a request while full must be ignored.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 2*i + 1, 1, 1, 2*i + 2, 0);
    checkOutput("full_count", int'(relq.count), 8);
    checkOutput("full_com_ready", int'(relq.com_ready), 0);
    applyStimulus(1, 1, 40, 1, 1, 41, 0);
    checkOutput("full_ignored_count", int'(relq.count), 8);
    // Full queue draining 2 still refuses the requests presented this cycle.
    applyStimulus(1, 1, 30, 1, 1, 31, 1);
    checkOutput("drain0_comnum", int'(relq.comnum), 2);
    checkOutput("drain0_tag1", int'(relq.released_tag1), 1);
    checkOutput("drain0_tag2", int'(relq.released_tag2), 2);
    checkOutput("drain0_count", int'(relq.count), 6);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("drain_tag1", int'(relq.released_tag1), 2*i + 1);
      checkOutput("drain_tag2", int'(relq.released_tag2), 2*i + 2);
    end
    checkOutput("drained_count", int'(relq.count), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("empty_comnum", int'(relq.comnum), 0);

    // A slot that retires without writing a register returns nothing.
    applyStimulus(1, 0, 11, 1, 1, 12, 0);
    checkOutput("nowr_count", int'(relq.count), 1);
    // Count of 1 drains a single tag with tag2 zeroed.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("single_comnum", int'(relq.comnum), 1);
    checkOutput("single_tag1", int'(relq.released_tag1), 12);
    checkOutput("single_tag2", int'(relq.released_tag2), 0);
    checkOutput("single_count", int'(relq.count), 0);

    // Steady state: 2 in / 2 out for 20 cycles, wrapping the pointers five times.
    applyStimulus(1, 1, 20, 1, 1, 21, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, 1, 22 + 2*k, 1, 1, 23 + 2*k, 1);
      checkOutput("stream_tag1", int'(relq.released_tag1), 20 + 2*k);
      checkOutput("stream_tag2", int'(relq.released_tag2), 21 + 2*k);
      checkOutput("stream_count", int'(relq.count), 2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("stream_last_tag1", int'(relq.released_tag1), 60);
    checkOutput("stream_last_tag2", int'(relq.released_tag2), 61);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_tag1", int'(relq.released_tag1), 60);
    checkOutput("hold_comnum", int'(relq.comnum), 0);

    // Reset with 5 tags queued discards them.
    applyStimulus(1, 1, 1, 1, 1, 2, 0);
    applyStimulus(1, 1, 3, 1, 1, 4, 0);
    applyStimulus(0, 0, 0, 1, 1, 5, 0);
    checkOutput("pre_reset_count", int'(relq.count), 5);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    checkOutput("mid_reset_count", int'(relq.count), 0);
    checkOutput("mid_reset_comnum", int'(relq.comnum), 0);
    checkOutput("mid_reset_com_ready", int'(relq.com_ready), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("post_reset_comnum", int'(relq.comnum), 0);

`ifdef RELQ_BYPASS_EN
    // Empty draining queue forwards both tags at the same edge.
    applyStimulus(1, 1, 9, 1, 1, 10, 1);
    checkOutput("bypass_comnum", int'(relq.comnum), 2);
    checkOutput("bypass_tag1", int'(relq.released_tag1), 9);
    checkOutput("bypass_tag2", int'(relq.released_tag2), 10);
    checkOutput("bypass_count", int'(relq.count), 0);
`else
    applyStimulus(1, 1, 9, 1, 1, 10, 1);
    checkOutput("fifo_pair_count", int'(relq.count), 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("fifo_pair_tag1", int'(relq.released_tag1), 9);
    checkOutput("fifo_pair_tag2", int'(relq.released_tag2), 10);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
